// File: rtl/control_sequencer.sv
//==============================================================================
// Module      : control_sequencer
// Description : Microcode fetch/execute sequencer driving the bus-CPU strobes.
//               Optional macro CONDITIONAL_JUMP_EN enables JC/JZ decode.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module control_sequencer #(
    parameter int STEPS = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      run,
    input  logic [3:0]                opcode,
    input  logic                      carry_flag,
    input  logic                      zero_flag,
    output logic                      hlt,
    output logic                      mar_in,
    output logic                      ram_in,
    output logic                      ram_out,
    output logic                      ir_in,
    output logic                      ir_out,
    output logic                      a_in,
    output logic                      a_out,
    output logic                      b_in,
    output logic                      alu_out,
    output logic                      alu_sub,
    output logic                      out_in,
    output logic                      flags_in,
    output logic                      pc_inc,
    output logic                      pc_jump,
    output logic                      pc_out,
    output logic                      halted,
    output logic [$clog2(STEPS)-1:0]  step
);

    localparam int c_SW = $clog2(STEPS);

    localparam logic [3:0] c_OP_LDA = 4'h1;
    localparam logic [3:0] c_OP_ADD = 4'h2;
    localparam logic [3:0] c_OP_SUB = 4'h3;
    localparam logic [3:0] c_OP_STA = 4'h4;
    localparam logic [3:0] c_OP_LDI = 4'h5;
    localparam logic [3:0] c_OP_JMP = 4'h6;
    localparam logic [3:0] c_OP_JC  = 4'h7;
    localparam logic [3:0] c_OP_JZ  = 4'h8;
    localparam logic [3:0] c_OP_OUT = 4'hE;
    localparam logic [3:0] c_OP_HLT = 4'hF;

    logic [c_SW-1:0] r_step;
    logic            r_halted;
    logic [c_SW-1:0] w_last;
    logic            w_wrap;
    logic            w_active;

    assign step     = r_step;
    assign halted   = r_halted;
    assign w_active = rst_n && run && !r_halted;

    // Every opcode runs at least through T2, so opcode is never consulted
    // for the wrap decision during fetch.
    always_comb begin
        w_last = c_SW'(2);
        case (opcode)
            c_OP_LDA, c_OP_STA: w_last = c_SW'(3);
            c_OP_ADD, c_OP_SUB: w_last = c_SW'(4);
            default:            w_last = c_SW'(2);
        endcase
    end

    assign w_wrap = (r_step == w_last) || (r_step == c_SW'(STEPS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_step   <= '0;
            r_halted <= 1'b0;
        end else if (run && !r_halted) begin
            r_step <= w_wrap ? '0 : r_step + c_SW'(1);
            if (hlt) begin
                r_halted <= 1'b1;
            end
        end
    end

`ifndef CONDITIONAL_JUMP_EN
    logic w_unused_flags;
    assign w_unused_flags = carry_flag ^ zero_flag;
`endif

    always_comb begin
        hlt      = 1'b0;
        mar_in   = 1'b0;
        ram_in   = 1'b0;
        ram_out  = 1'b0;
        ir_in    = 1'b0;
        ir_out   = 1'b0;
        a_in     = 1'b0;
        a_out    = 1'b0;
        b_in     = 1'b0;
        alu_out  = 1'b0;
        alu_sub  = 1'b0;
        out_in   = 1'b0;
        flags_in = 1'b0;
        pc_inc   = 1'b0;
        pc_jump  = 1'b0;
        pc_out   = 1'b0;
        if (w_active) begin
            case (r_step)
                c_SW'(0): begin
                    pc_out = 1'b1;
                    mar_in = 1'b1;
                end
                c_SW'(1): begin
                    ram_out = 1'b1;
                    ir_in   = 1'b1;
                    pc_inc  = 1'b1;
                end
                c_SW'(2): begin
                    case (opcode)
                        c_OP_LDA, c_OP_ADD, c_OP_SUB, c_OP_STA: begin
                            ir_out = 1'b1;
                            mar_in = 1'b1;
                        end
                        c_OP_LDI: begin
                            ir_out = 1'b1;
                            a_in   = 1'b1;
                        end
                        c_OP_JMP: begin
                            ir_out  = 1'b1;
                            pc_jump = 1'b1;
                        end
`ifdef CONDITIONAL_JUMP_EN
                        c_OP_JC: begin
                            ir_out  = carry_flag;
                            pc_jump = carry_flag;
                        end
                        c_OP_JZ: begin
                            ir_out  = zero_flag;
                            pc_jump = zero_flag;
                        end
`endif
                        c_OP_OUT: begin
                            a_out  = 1'b1;
                            out_in = 1'b1;
                        end
                        c_OP_HLT: hlt = 1'b1;
                        default: ;
                    endcase
                end
                c_SW'(3): begin
                    case (opcode)
                        c_OP_LDA: begin
                            ram_out = 1'b1;
                            a_in    = 1'b1;
                        end
                        c_OP_ADD, c_OP_SUB: begin
                            ram_out = 1'b1;
                            b_in    = 1'b1;
                        end
                        c_OP_STA: begin
                            a_out  = 1'b1;
                            ram_in = 1'b1;
                        end
                        default: ;
                    endcase
                end
                c_SW'(4): begin
                    if (opcode == c_OP_ADD || opcode == c_OP_SUB) begin
                        alu_out  = 1'b1;
                        a_in     = 1'b1;
                        flags_in = 1'b1;
                        alu_sub  = (opcode == c_OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire
